// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage and its next-PC selector.
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_FETCH = 2'b01,
        ST_VALID = 2'b10,
        ST_TRAP  = 2'b11
    } fetch_state_t;

    // Encoding shared with the control decoder's PCSrc output.
    localparam logic [1:0] PCSRC_PLUS4  = 2'b00;
    localparam logic [1:0] PCSRC_TARGET = 2'b01;
    localparam logic [1:0] PCSRC_JALR   = 2'b10;

    localparam logic [1:0] TRAP_NONE     = 2'b00;
    localparam logic [1:0] TRAP_MISALIGN = 2'b01;
    localparam logic [1:0] TRAP_TIMEOUT  = 2'b10;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/instr_fetch_if.sv
// Instruction memory read bus: the fetch stage is the master, the memory is the slave.
interface instr_fetch_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rvalid,
        output imem_rdata
    );

endinterface

// File: rtl/instr_fetch_next_pc_sel.sv
// Combinational next-PC multiplexer with word-alignment check on the selected target.
module next_pc_sel
    import fetch_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [1:0]  pc_src,
    input  logic [31:0] pc_target,
    input  logic [31:0] alu_result,
    output logic [31:0] pc_plus4,
    output logic [31:0] next_pc,
    output logic        misaligned
);

    assign pc_plus4 = pc + 32'd4;

    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
    always_comb begin
        next_pc = pc_plus4;
        case (pc_src)
            PCSRC_TARGET: next_pc = pc_target;
            PCSRC_JALR:   next_pc = alu_result & ~32'h0000_0001;
            default:      next_pc = pc_plus4;
        endcase
    end

    assign misaligned = (next_pc[1:0] != 2'b00);

endmodule

// File: rtl/instr_fetch.sv
// Multi-cycle fetch stage: owns the PC, fetches from variable-latency memory, holds the
// instruction until retirement, traps on misaligned targets and memory timeouts.
module instr_fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          TIMEOUT  = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    instr_fetch_if.master        imem,
    output logic [31:0]          Instr,
    output logic [31:0]          PC,
    output logic [31:0]          PCPlus4,
    output logic                 instr_valid,
    input  logic                 retire,
    input  logic [1:0]           PCSrc,
    input  logic [31:0]          PCTarget,
    input  logic [31:0]          ALUResult,
    output logic                 trap,
    output logic [1:0]           trap_cause,
    output logic [31:0]          trap_pc,
    output logic [31:0]          instret
);

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    fetch_state_t state, state_next;
    logic [7:0]   timeout_cnt;
    logic [31:0]  next_pc;
    logic         misaligned;
    logic         timeout_hit;

    next_pc_sel u_next_pc_sel (
        .pc         (PC),
        .pc_src     (PCSrc),
        .pc_target  (PCTarget),
        .alu_result (ALUResult),
        .pc_plus4   (PCPlus4),
        .next_pc    (next_pc),
        .misaligned (misaligned)
    );

    assign timeout_hit    = (timeout_cnt == TIMEOUT_LAST);
    assign imem.imem_addr = PC;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  state_next = ST_FETCH;
            ST_FETCH: begin
                if (imem.imem_rvalid)  state_next = ST_VALID;
                else if (timeout_hit)  state_next = ST_TRAP;
            end
            ST_VALID: begin
                if (retire) state_next = misaligned ? ST_TRAP : ST_FETCH;
            end
            default:  state_next = ST_TRAP;
        endcase
    end

    always_comb begin
        imem.imem_req = 1'b0;
        instr_valid   = 1'b0;
        trap          = 1'b0;
        case (state)
            ST_FETCH: imem.imem_req = 1'b1;
            ST_VALID: instr_valid   = 1'b1;
            ST_TRAP:  trap          = 1'b1;
            default:  ;
        endcase
    end

    // Datapath registers; Instr is only loaded in FETCH so the decoder always sees a stable word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            PC          <= RESET_PC;
            Instr       <= NOP_INSTR;
            trap_cause  <= TRAP_NONE;
            trap_pc     <= 32'h0000_0000;
            instret     <= 32'h0000_0000;
            timeout_cnt <= 8'd0;
        end else begin
            case (state)
                ST_IDLE: timeout_cnt <= 8'd0;
                ST_FETCH: begin
                    if (imem.imem_rvalid) begin
                        Instr       <= imem.imem_rdata;
                        timeout_cnt <= 8'd0;
                    end else if (timeout_hit) begin
                        trap_cause <= TRAP_TIMEOUT;
                        trap_pc    <= PC;
                    end else begin
                        timeout_cnt <= timeout_cnt + 8'd1;
                    end
                end
                ST_VALID: begin
                    if (retire) begin
                        instret <= instret + 32'd1;
                        if (misaligned) begin
                            trap_cause <= TRAP_MISALIGN;
                            trap_pc    <= next_pc;
                        end else begin
                            PC          <= next_pc;
                            timeout_cnt <= 8'd0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
